// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: result bus type and source indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cdb_arbiter_pkg;

  localparam int NUM_CDB_SRC = 4;

  localparam logic [1:0] SRC_INT  = 2'd0;
  localparam logic [1:0] SRC_MULT = 2'd1;
  localparam logic [1:0] SRC_DIV  = 2'd2;
  localparam logic [1:0] SRC_MEM  = 2'd3;

  // Result bus as produced by the functional units. Only valid is interpreted
  // by the arbiter; every other field is carried through untouched.
  typedef struct packed {
    logic        valid;
    logic [5:0]  tag;
    logic [31:0] data;
  } cdb_bfm;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO holding results that lost CDB arbitration.
// Latency: a pushed entry becomes the head on the next cycle; head is read combinationally.
// Backpressure: none; a push into a full FIFO without a same-cycle pop is ignored (caller flags it).
// Ports: clk/rst_n, push/pop/flush controls, din in, head/empty/full/count out.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  cdb_bfm                     din,
  output cdb_bfm                     head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  cdb_bfm          mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q;
  logic [AW:0]     rd_ptr_q;
  logic            push_ok;
  logic            pop_ok;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // When full, a simultaneous pop frees the slot being written this edge.
  assign push_ok = push && !flush && (!full || pop);
  assign pop_ok  = pop && !flush && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter placing one of four unit results per cycle on the common data bus.
// Latency: 0 cycles for a result bypassing an empty FIFO; queued results compete from the next cycle.
// Backpressure: none to units; registered per-source hold tells issue to stop, overflow flags a drop.
// Ports: i_clk, i_rst_n, flush; {int,mult,div,mem}_submit_data in; cdb_out, o_cdb_src,
//        o_hold (bit order int,mult,div,mem), o_overflow (sticky until reset) out.
// DEPTH must be a power of two, >= 4, and >= every unit latency + 2.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_MARGIN = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        flush,
  input  cdb_bfm      int_submit_data,
  input  cdb_bfm      mult_submit_data,
  input  cdb_bfm      div_submit_data,
  input  cdb_bfm      mem_submit_data,
  output cdb_bfm      cdb_out,
  output logic [1:0]  o_cdb_src,
  output logic [3:0]  o_hold,
  output logic        o_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  cdb_bfm                 in_bus     [NUM_CDB_SRC];
  cdb_bfm                 fifo_head  [NUM_CDB_SRC];
  logic [CW-1:0]          fifo_count [NUM_CDB_SRC];
  logic [CW-1:0]          count_next [NUM_CDB_SRC];
  logic [NUM_CDB_SRC-1:0] fifo_empty;
  logic [NUM_CDB_SRC-1:0] fifo_full;
  logic [NUM_CDB_SRC-1:0] cand_vld;
  logic [NUM_CDB_SRC-1:0] won;
  logic [NUM_CDB_SRC-1:0] pop;
  logic [NUM_CDB_SRC-1:0] push_req;
  logic [NUM_CDB_SRC-1:0] push;
  logic [NUM_CDB_SRC-1:0] drop;
  logic [NUM_CDB_SRC-1:0] hold_next;

  logic [1:0] rr_q;
  logic [1:0] scan_idx;
  logic [1:0] win_idx;
  logic       win_vld;

  assign in_bus[SRC_INT]  = int_submit_data;
  assign in_bus[SRC_MULT] = mult_submit_data;
  assign in_bus[SRC_DIV]  = div_submit_data;
  assign in_bus[SRC_MEM]  = mem_submit_data;

  for (genvar k = 0; k < NUM_CDB_SRC; k++) begin : g_src
    // A queued head always takes precedence over the live input so a
    // source's results leave in arrival order.
    assign cand_vld[k] = !fifo_empty[k] || in_bus[k].valid;
    assign won[k]      = win_vld && (win_idx == 2'(k));
    assign pop[k]      = won[k] && !fifo_empty[k];
    // A bypass winner is consumed directly, so it is not queued.
    assign push_req[k] = in_bus[k].valid && !flush && !(won[k] && fifo_empty[k]);
    assign push[k]     = push_req[k] && (!fifo_full[k] || pop[k]);
    assign drop[k]     = push_req[k] && fifo_full[k] && !pop[k];
    assign count_next[k] = flush ? '0
                         : fifo_count[k] + CW'(push[k]) - CW'(pop[k]);
    assign hold_next[k]  = (DEPTH - int'(count_next[k])) <= HOLD_MARGIN;

    cdb_src_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .push  (push[k]),
      .pop   (pop[k]),
      .flush (flush),
      .din   (in_bus[k]),
      .head  (fifo_head[k]),
      .empty (fifo_empty[k]),
      .full  (fifo_full[k]),
      .count (fifo_count[k])
    );
  end

  // Scan from the round-robin pointer and take the first source with a candidate.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = rr_q;
    scan_idx = '0;
    for (int i = 0; i < NUM_CDB_SRC; i++) begin
      scan_idx = rr_q + 2'(i);
      if (!win_vld && cand_vld[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
    // Nothing broadcasts during a flush or while held in reset.
    if (flush || !i_rst_n) win_vld = 1'b0;
  end

  always_comb begin
    cdb_out   = '0;
    o_cdb_src = '0;
    if (win_vld) begin
      cdb_out       = fifo_empty[win_idx] ? in_bus[win_idx] : fifo_head[win_idx];
      cdb_out.valid = 1'b1;
      o_cdb_src     = win_idx;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_q       <= '0;
      o_hold     <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (flush) begin
        rr_q   <= '0;
        o_hold <= '0;
      end else begin
        if (win_vld) rr_q <= win_idx + 2'd1;
        o_hold <= hold_next;
      end
      if (|drop) o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: bypass, round-robin, ordering, hold, overflow, flush, reset.
// Latency: inputs applied at the falling edge, combinational outputs sampled 1 time unit later.
// Backpressure: n/a.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       flush;
  cdb_bfm     int_d;
  cdb_bfm     mult_d;
  cdb_bfm     div_d;
  cdb_bfm     mem_d;
  cdb_bfm     cdb_out;
  logic [1:0] cdb_src;
  logic [3:0] hold;
  logic       overflow;

  int checks;
  int errors;

  cdb_bfm nb;

  cdb_arbiter #(
    .DEPTH       (8),
    .HOLD_MARGIN (4)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .flush            (flush),
    .int_submit_data  (int_d),
    .mult_submit_data (mult_d),
    .div_submit_data  (div_d),
    .mem_submit_data  (mem_d),
    .cdb_out          (cdb_out),
    .o_cdb_src        (cdb_src),
    .o_hold           (hold),
    .o_overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cdb_bfm mk(input logic [5:0] t);
    cdb_bfm r;
    r.valid = 1'b1;
    r.tag   = t;
    r.data  = 32'hC0DE_0000 | {26'h0, t};
    return r;
  endfunction

  task automatic cyc(input cdb_bfm a, input cdb_bfm b, input cdb_bfm c,
                     input cdb_bfm d, input logic fl);
    @(negedge clk);
    int_d  = a;
    mult_d = b;
    div_d  = c;
    mem_d  = d;
    flush  = fl;
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Expected broadcast: valid, and when valid also source, tag and data.
  task automatic chk_out(input string name, input logic vld, input logic [1:0] src,
                         input logic [5:0] tag);
    cdb_bfm e;
    e = mk(tag);
    chk({name, ".valid"}, 32'(cdb_out.valid), 32'(vld));
    if (vld) begin
      chk({name, ".src"},  32'(cdb_src), 32'(src));
      chk({name, ".tag"},  32'(cdb_out.tag), 32'(tag));
      chk({name, ".data"}, cdb_out.data, e.data);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nb     = '0;
    rst_n  = 1'b0;
    flush  = 1'b0;
    int_d  = '0;
    mult_d = '0;
    div_d  = '0;
    mem_d  = '0;

    // Reset state
    #1;
    chk("rst.valid", 32'(cdb_out.valid), 0);
    chk("rst.src", 32'(cdb_src), 0);
    chk("rst.hold", 32'(hold), 0);
    chk("rst.ovf", 32'(overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single int result bypasses in the same cycle
    cyc(mk(6'd5), nb, nb, nb, 1'b0);
    chk_out("byp", 1'b1, SRC_INT, 6'd5);
    chk("byp.hold", 32'(hold), 0);
    cyc(nb, nb, nb, nb, 1'b0);
    chk_out("byp.idle", 1'b0, 2'd0, 6'd0);
    chk("byp.hold2", 32'(hold), 0);
    // Flush with nothing queued returns rr to 0
    cyc(nb, nb, nb, nb, 1'b1);
    chk_out("fl0", 1'b0, 2'd0, 6'd0);

    // All four valid together: int, mult, div, mem on consecutive cycles
    cyc(mk(6'd10), mk(6'd11), mk(6'd12), mk(6'd13), 1'b0);
    chk_out("rr0", 1'b1, SRC_INT, 6'd10);
    cyc(nb, nb, nb, nb, 1'b0);
    chk_out("rr1", 1'b1, SRC_MULT, 6'd11);
    cyc(nb, nb, nb, nb, 1'b0);
    chk_out("rr2", 1'b1, SRC_DIV, 6'd12);
    cyc(nb, nb, nb, nb, 1'b0);
    chk_out("rr3", 1'b1, SRC_MEM, 6'd13);
    cyc(nb, nb, nb, nb, 1'b0);
    chk_out("rr.idle", 1'b0, 2'd0, 6'd0);

    // Int every cycle for 10 cycles, mult once in cycle 0 (rr back at 0)
    for (int c = 0; c <= 10; c++) begin
      cyc((c < 10) ? mk(6'(20 + c)) : nb, (c == 0) ? mk(6'd40) : nb, nb, nb, 1'b0);
      if (c == 0)      chk_out($sformatf("ord%0d", c), 1'b1, SRC_INT, 6'd20);
      else if (c == 1) chk_out($sformatf("ord%0d", c), 1'b1, SRC_MULT, 6'd40);
      else             chk_out($sformatf("ord%0d", c), 1'b1, SRC_INT, 6'(20 + c - 1));
    end
    cyc(nb, nb, nb, nb, 1'b0);
    chk_out("ord.idle", 1'b0, 2'd0, 6'd0);
    cyc(nb, nb, nb, nb, 1'b1);

    // Mem FIFO reaches 4 entries -> hold[3] for one cycle, then drains
    cyc(mk(6'd60), mk(6'd70), mk(6'd71), mk(6'd50), 1'b0);
    chk_out("h0", 1'b1, SRC_INT, 6'd60);
    cyc(nb, nb, nb, mk(6'd51), 1'b0);
    chk_out("h1", 1'b1, SRC_MULT, 6'd70);
    cyc(nb, nb, nb, mk(6'd52), 1'b0);
    chk_out("h2", 1'b1, SRC_DIV, 6'd71);
    cyc(nb, nb, nb, mk(6'd53), 1'b0);
    chk_out("h3", 1'b1, SRC_MEM, 6'd50);
    cyc(mk(6'd61), nb, nb, mk(6'd54), 1'b0);
    chk_out("h4", 1'b1, SRC_INT, 6'd61);
    chk("h4.hold", 32'(hold), 32'h0);
    cyc(nb, nb, nb, nb, 1'b0);
    chk_out("h5", 1'b1, SRC_MEM, 6'd51);
    chk("h5.hold", 32'(hold), 32'h8);
    cyc(nb, nb, nb, nb, 1'b0);
    chk_out("h6", 1'b1, SRC_MEM, 6'd52);
    chk("h6.hold", 32'(hold), 32'h0);
    cyc(nb, nb, nb, nb, 1'b0);
    chk_out("h7", 1'b1, SRC_MEM, 6'd53);
    cyc(nb, nb, nb, nb, 1'b0);
    chk_out("h8", 1'b1, SRC_MEM, 6'd54);
    cyc(nb, nb, nb, nb, 1'b0);
    chk_out("h.idle", 1'b0, 2'd0, 6'd0);

    // All four valid every cycle: mem reaches 8 and drops at cycle 10
    for (int c = 0; c <= 10; c++) begin
      cyc(mk(6'd1), mk(6'd2), mk(6'd3), mk(6'd4), 1'b0);
      chk($sformatf("ov%0d.src", c), 32'(cdb_src), 32'(c % 4));
      if (c == 10) begin
        chk("ov10.hold", 32'(hold), 32'hF);
        chk("ov10.ovf", 32'(overflow), 0);
      end
    end

    // Flush with results queued; inputs during flush are discarded
    cyc(mk(6'd90), nb, nb, nb, 1'b1);
    chk_out("fl", 1'b0, 2'd0, 6'd0);
    chk("fl.ovf", 32'(overflow), 1);
    cyc(nb, nb, nb, nb, 1'b0);
    chk_out("fl.empty", 1'b0, 2'd0, 6'd0);
    chk("fl.hold", 32'(hold), 0);
    chk("fl.ovf2", 32'(overflow), 1);
    cyc(mk(6'd91), nb, nb, nb, 1'b0);
    chk_out("fl.byp", 1'b1, SRC_INT, 6'd91);

    // Reset mid-operation discards queued results and clears overflow
    cyc(mk(6'd92), mk(6'd93), nb, nb, 1'b0);
    chk_out("ar.pre", 1'b1, SRC_MULT, 6'd93);
    @(negedge clk);
    int_d  = nb;
    mult_d = nb;
    rst_n  = 1'b0;
    #1;
    chk_out("ar.in", 1'b0, 2'd0, 6'd0);
    chk("ar.ovf", 32'(overflow), 0);
    chk("ar.hold", 32'(hold), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_out("ar.post", 1'b0, 2'd0, 6'd0);
    cyc(nb, nb, nb, nb, 1'b0);
    chk_out("ar.post2", 1'b0, 2'd0, 6'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Sits directly downstream of the functional unit group. Takes the four per-unit submit buses (int, mult, div, mem) and places one result per cycle on the single common data bus (CDB).
- The CDB is consumed by the ROB, the reservation stations and the register status table.
- Execution units have no output backpressure, so each source gets a small FIFO that absorbs results losing arbitration.
- Emits per-unit hold signals so issue logic stops granting a unit before its FIFO can overflow.

Parameters:
- DEPTH, 8, entries per source FIFO; must be a power of 2 and at least 4. Must be at least (unit latency + 2) for every unit.
- HOLD_MARGIN, 4, the hold signal for a unit asserts when its FIFO free entries are at or below this value. This covers results already in flight in the unit pipelines (div latency 6 is bounded by its own busy signal).

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous pipeline flush (mispredict)
- int_submit_data  in  cdb_bfm  int unit result
- mult_submit_data  in  cdb_bfm  mult unit result
- div_submit_data  in  cdb_bfm  div unit result
- mem_submit_data  in  cdb_bfm  mem unit result
- cdb_out  out  cdb_bfm  broadcast result, at most one per cycle
- o_cdb_src  out  2  source index of cdb_out: 0 int, 1 mult, 2 div, 3 mem
- o_hold  out  4  per-source hold to issue logic, same bit order as o_cdb_src
- o_overflow  out  1  sticky error flag: a result was dropped

Behaviour:
- Reset (async, i_rst_n=0):
  - all FIFOs empty
  - cdb_out.valid=0, o_cdb_src=0, o_hold=0, o_overflow=0
  - round-robin pointer rr=0
- cdb_bfm handling: only .valid is interpreted. All other fields pass through unmodified.
- Candidate for source k:
  - the FIFO head if FIFO k is non-empty;
  - otherwise the input bus k if its .valid=1;
  - otherwise none.
- Arbitration (combinational, same cycle):
  - scan k = rr, rr+1, ... mod 4 and pick the first source with a candidate.
  - drive cdb_out with that candidate, o_cdb_src=k, cdb_out.valid=1.
  - if no source has a candidate: cdb_out.valid=0 and the other fields are don't-care (drive the zero struct).
- Bypass latency: a result arriving at an empty FIFO that wins arbitration appears on cdb_out in the same cycle (0 added latency).
- Queued latency: a result that loses is pushed into its FIFO at the clock edge and competes from the next cycle.
- Per-source update at each edge, for every source k:
  - k won from the FIFO: pop the head; push the input if it is valid (simultaneous push and pop, count unchanged).
  - k won via bypass: no push, no pop.
  - k lost or had no win: push the input if it is valid.
- Ordering: results from one source leave in arrival order. A new input never bypasses a non-empty FIFO.
- Pointer update: when cdb_out.valid=1, rr <= (winner+1) mod 4 at the edge. Otherwise rr holds.
- Full FIFO: a push into a full FIFO with no simultaneous pop drops the input and sets o_overflow=1. o_overflow stays set until reset, including through flush.
- Hold signal, registered: o_hold[k] <= (DEPTH - count_k_next) <= HOLD_MARGIN.
- Flush (flush=1):
  - cdb_out.valid forced 0 that cycle
  - all FIFOs cleared at the edge; inputs of that cycle are not pushed
  - rr reset to 0; o_hold cleared at the edge
- FIFO pointers are log2(DEPTH)+1 bits; wrap-around via the extra MSB distinguishes full from empty.
- Reset mid-operation discards all queued results immediately (asynchronous).

Decomposition:
- Shared package (utils): cdb_bfm typedef (existing), source index constants SRC_INT=0, SRC_MULT=1, SRC_DIV=2, SRC_MEM=3, and NUM_CDB_SRC=4.
- Sub-module cdb_src_fifo: parameter DEPTH, cdb_bfm data. Ports: push, pop, flush, head, empty, full, count. Instantiate four times.
- The arbiter, rr pointer and hold logic stay in the top.

Test Plan:
- Single int result, tag 5, all FIFOs empty -> cdb_out.valid=1 in the same cycle, o_cdb_src=0, o_hold=0, no FIFO activity.
- int, mult, div and mem all valid in the same cycle, rr=0 -> CDB order int, mult, div, mem over 4 consecutive cycles, each one cycle. rr returns to 0 after mem.
- int valid every cycle for 10 cycles while mult is valid in cycle 0 -> mult broadcasts in cycle 1. All 10 int results appear in order, last one at cycle 10.
- Mem FIFO filled to 4 entries while other sources are contended -> o_hold[3]=1 the cycle after count reaches 4. It deasserts once count is 3.
- Push 9 results into mem with DEPTH=8 and mem never winning -> 9th dropped, o_overflow=1 and stays 1.
- 3 results queued across sources, flush=1 -> cdb_out.valid=0 that cycle, all FIFOs empty next cycle. A new int result after flush bypasses with o_cdb_src=0.
